// File: rtl/serial_tx.sv
// Byte-wide UART-style serializer: start bit, 8 data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps

module serial_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SERIAL_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       tx_out_q, tx_out_d;
   logic       tx_ready_q, tx_ready_d;
   logic       busy_q, busy_d;
   logic       bit_done;
`ifdef SERIAL_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   assign bit_done = (cnt_q == LAST_CNT);

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      tx_out_d   = tx_out_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               shift_d    = tx_data;
`ifdef SERIAL_TX_PARITY_EN
               parity_d   = ^tx_data;
`endif
               cnt_d      = 8'd0;
               idx_d      = 3'd0;
               state_d    = START;
               tx_out_d   = 1'b0;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               cnt_d    = 8'd0;
               state_d  = DATA;
               tx_out_d = shift_q[0];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d = 8'd0;
               if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d  = PARITY;
                  tx_out_d = parity_q;
`else
                  state_d  = STOP;
                  tx_out_d = 1'b1;
`endif
               end else begin
                  // Line always shows shift_q[0]; shift right to expose the next bit.
                  idx_d    = idx_q + 3'd1;
                  shift_d  = {1'b0, shift_q[7:1]};
                  tx_out_d = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               cnt_d    = 8'd0;
               state_d  = STOP;
               tx_out_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               cnt_d      = 8'd0;
               state_d    = IDLE;
               tx_out_d   = 1'b1;
               tx_ready_d = 1'b1;
               busy_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_out_d   = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; rst acts without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         idx_q      <= 3'd0;
         shift_q    <= 8'd0;
         tx_out_q   <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         tx_out_q   <= tx_out_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx_out   = tx_out_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

endmodule
